// File: rtl/axi_ready_gen_mc.sv
// Multi-channel AXI READY generator: per-channel ALWAYS / OSC / OSC_ON_VALID / RANDOM
// ready patterns with saturating per-channel handshake counters.
module axi_ready_gen_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 8,
  parameter int          HS_W      = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [2*NUM_CH-1:0]     cfg_mode,
  input  logic [CNT_W*NUM_CH-1:0] cfg_low_time,
  input  logic [CNT_W*NUM_CH-1:0] cfg_high_time,
  input  logic [NUM_CH-1:0]       valid_in,
  output logic [NUM_CH-1:0]       ready_out,
  output logic [HS_W*NUM_CH-1:0]  hs_count
);

  typedef enum logic [1:0] {
    M_ALWAYS    = 2'd0,
    M_OSC       = 2'd1,
    M_OSC_VALID = 2'd2,
    M_RANDOM    = 2'd3
  } mode_e;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [NUM_CH-1:0] rdy_q, rdy_d;
  mode_e             mode_q  [NUM_CH];
  mode_e             mode_d  [NUM_CH];
  logic [CNT_W-1:0]  low_q   [NUM_CH];
  logic [CNT_W-1:0]  low_d   [NUM_CH];
  logic [CNT_W-1:0]  high_q  [NUM_CH];
  logic [CNT_W-1:0]  high_d  [NUM_CH];
  phase_e            state_q [NUM_CH];
  phase_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [HS_W-1:0]   hs_q    [NUM_CH];
  logic [HS_W-1:0]   hs_d    [NUM_CH];

  always_comb begin
    logic             adv;
    logic [CNT_W-1:0] high_last;
    adv       = 1'b0;
    high_last = '0;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rdy_d     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mode_d[i]  = mode_q[i];
      low_d[i]   = low_q[i];
      high_d[i]  = high_q[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hs_d[i]    = hs_q[i];

      // Handshake uses the ready currently on the bus, so it counts even on a load cycle.
      if (valid_in[i] && rdy_q[i] && (hs_q[i] != '1)) begin
        hs_d[i] = hs_q[i] + HS_W'(1);
      end

      adv       = (mode_q[i] == M_OSC) || ((mode_q[i] == M_OSC_VALID) && valid_in[i]);
      // A zero high time behaves as one cycle so the channel can never stall low.
      high_last = (high_q[i] == '0) ? '0 : high_q[i] - CNT_W'(1);

      if (cfg_load[i]) begin
        mode_d[i]  = mode_e'(cfg_mode[2*i +: 2]);
        low_d[i]   = cfg_low_time[CNT_W*i +: CNT_W];
        high_d[i]  = cfg_high_time[CNT_W*i +: CNT_W];
        state_d[i] = PH_LOW;
        cnt_d[i]   = '0;
        rdy_d[i]   = (mode_e'(cfg_mode[2*i +: 2]) == M_ALWAYS);
      end else begin
        if (adv) begin
          if (state_q[i] == PH_LOW) begin
            if ((low_q[i] == '0) || (cnt_q[i] == low_q[i] - CNT_W'(1))) begin
              state_d[i] = PH_HIGH;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end else if (cnt_q[i] == high_last) begin
            // With no low phase the channel re-enters HIGH directly.
            state_d[i] = (low_q[i] == '0) ? PH_HIGH : PH_LOW;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        case (mode_q[i])
          M_ALWAYS: rdy_d[i] = 1'b1;
          M_RANDOM: rdy_d[i] = lfsr_q[4'(i % 16)];
          default:  rdy_d[i] = (state_d[i] == PH_HIGH);
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      lfsr_q <= LFSR_SEED;
      rdy_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= M_ALWAYS;
        low_q[i]   <= CNT_W'(1);
        high_q[i]  <= CNT_W'(1);
        state_q[i] <= PH_LOW;
        cnt_q[i]   <= '0;
        hs_q[i]    <= '0;
      end
    end else begin
      lfsr_q  <= lfsr_d;
      rdy_q   <= rdy_d;
      mode_q  <= mode_d;
      low_q   <= low_d;
      high_q  <= high_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
    end
  end

  assign ready_out = rdy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_hs
    assign hs_count[HS_W*g +: HS_W] = hs_q[g];
  end

endmodule

// File: doc/axi_ready_gen_mc.md
AXI_READY_GEN_MC -- requirements
Module: axi_ready_gen_mc

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CH, 2, number of independent ready channels (1..8).
- CNT_W, 8, width of the phase-time fields.
- HS_W, 16, width of the per-channel handshake counters.
- LFSR_SEED, 16'hACE1, non-zero reset seed for the shared LFSR.
REQ-002 Ports SHALL be, one per line:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
- cfg_load  in  NUM_CH  per-channel configuration load strobe.
- cfg_mode  in  2*NUM_CH  per-channel mode; 0 ALWAYS, 1 OSC, 2 OSC_ON_VALID, 3 RANDOM.
- cfg_low_time  in  CNT_W*NUM_CH  per-channel low-phase length in cycles.
- cfg_high_time  in  CNT_W*NUM_CH  per-channel high-phase length in cycles.
- valid_in  in  NUM_CH  VALID of the observed channel.
- ready_out  out  NUM_CH  generated READY.
- hs_count  out  HS_W*NUM_CH  per-channel count of completed handshakes (valid_in & ready_out).
REQ-003 The block SHALL use one clock, ACLK; reset ARESETN SHALL be synchronous and active-low.
REQ-004 Channel i SHALL use bit slice i of cfg_load, valid_in and ready_out, and field slice i of every other multi-channel port.

Function
REQ-005 ready_out SHALL be a direct register output with no combinational path from any input.
REQ-006 Each channel SHALL hold latched registers mode, low_t and high_t, plus a phase state LOW/HIGH and a CNT_W phase counter.
REQ-007 On cfg_load[i]=1, channel i SHALL latch its cfg fields, enter LOW with counter=0, and drive ready_out[i]=0 on the next cycle, except in ALWAYS mode where it SHALL drive 1.
REQ-008 Effective lengths SHALL be applied at use time:
- low_t=0: the LOW phase is skipped.
- high_t=0: treated as 1, so the channel cannot deadlock.
REQ-009 ALWAYS: ready_out[i]=1 every cycle.
REQ-010 OSC: free-running; low_t cycles with ready=0, then high_t cycles with ready=1, repeating with period low_t+high_t, independent of valid_in.
REQ-011 OSC_ON_VALID: same pattern as OSC, but the phase counter advances only in cycles where valid_in[i]=1; otherwise state and counter hold.
REQ-012 RANDOM: ready_out[i] SHALL equal the LFSR bit (i mod 16) registered each cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle after reset.
REQ-013 In OSC and OSC_ON_VALID, the LOW-to-HIGH transition SHALL occur when the counter reaches low_t-1 in an advancing cycle.
REQ-014 In OSC and OSC_ON_VALID, the HIGH-to-LOW transition SHALL occur when the counter reaches high_t-1 in an advancing cycle; the counter resets to 0 on each transition.
REQ-015 hs_count[i] SHALL increment by 1 in each cycle where valid_in[i]=1 and ready_out[i]=1, and SHALL saturate at 2^HS_W-1.
REQ-016 cfg_load SHALL NOT clear hs_count.
REQ-017 When cfg_load[i] and a handshake occur in the same cycle, the handshake SHALL be counted and the new configuration SHALL apply from the next cycle.
REQ-018 Channels SHALL be fully independent; loading one channel SHALL NOT disturb the phase of any other channel.

Reset
REQ-019 While ARESETN=0 at a rising edge, the following SHALL result:
- ready_out=0 and hs_count=0.
- mode=ALWAYS, low_t=1, high_t=1.
- state=LOW, counter=0, LFSR=LFSR_SEED.
REQ-020 In the first cycle after reset release, ready_out SHALL be all ones (ALWAYS mode).
REQ-021 A reset asserted mid-phase SHALL abort the phase with no residual state.

Verification
REQ-022 Reset, then no load -> ready_out=0 during reset, 1 from the first post-reset cycle; valid_in held high for 10 cycles -> hs_count=10.
REQ-023 Load ch0 OSC, low=6, high=2 -> ready_out[0] repeats 6 cycles 0 / 2 cycles 1 (period 8) for at least 5 periods; ch1 stays unaffected.
REQ-024 Load ch1 OSC_ON_VALID, low=5, high=1, with valid_in[1] toggling every cycle -> phase lengths double (10 cycles low, 2 high); ready only advances on valid cycles.
REQ-025 Load OSC with low=0, high=0 -> ready_out constant 1; load low=3, high=0 -> pattern 0,0,0,1 repeating.
REQ-026 HS_W=4, ALWAYS mode, valid_in high for 20 cycles -> hs_count saturates at 15.
REQ-027 Assert ARESETN=0 mid-HIGH phase, then reload -> outputs match REQ-019/REQ-020 exactly; RANDOM mode after reset reproduces an identical bit sequence across two runs.
